// File: rtl/io_console_responder_if.sv
// io_console_responder_if
//  Bundles the CPU/board-side signals of the console responder.
//  master: CPU datapath + board pins (drives requests, Enter, switches, OUT value)
//  slave : responder (returns in_data, stall and the eight 7-segment digits)
//  Signals: in_req, out_req, halt, enter_n, sw[SW_WIDTH], out_data[32] -> responder
//           in_data[32], stall, hex0..hex7[7] (active-low, bit0=a..bit6=g) <- responder
interface io_console_responder_if #(
  parameter int unsigned SW_WIDTH = 10
) ();
  logic                in_req;
  logic                out_req;
  logic                halt;
  logic                enter_n;
  logic [SW_WIDTH-1:0] sw;
  logic [31:0]         out_data;
  logic [31:0]         in_data;
  logic                stall;
  logic [6:0]          hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  modport master (
    output in_req, out_req, halt, enter_n, sw, out_data,
    input  in_data, stall, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7
  );

  modport slave (
    input  in_req, out_req, halt, enter_n, sw, out_data,
    output in_data, stall, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7
  );
endinterface

// File: rtl/io_console_responder.sv
// io_console_responder
//  Device-side responder for the CPU IN/OUT/HLT handshake.
//  IN : waits for a debounced Enter press, returns the switches zero-extended, releases stall.
//  OUT: latches the value and converts it (sequential double-dabble) to signed decimal on
//       eight active-low 7-segment digits; hex7 shows '-', or 'H' while halt is high.
//  Ports: i_clk   system clock
//         i_rst_n asynchronous active-low reset
//         io_bus  io_console_responder_if.slave (requests, Enter, switches, in_data, stall, hex)
module io_console_responder #(
  parameter int unsigned DB_CYCLES = 1000,
  parameter int unsigned SW_WIDTH  = 10
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  io_console_responder_if.slave        io_bus
);
  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    unique case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // ---------------- Enter synchronizer + debouncer ----------------
  logic            r_sync1, r_sync2, r_db, r_press;
  logic [CntW-1:0] r_db_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_db     <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= io_bus.enter_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == CntW'(DB_CYCLES - 1)) begin
        // DB_CYCLES consecutive differing samples: accept the new level
        r_db_cnt <= '0;
        r_db     <= r_sync2;
        r_press  <= ~r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // ---------------- IN handshake FSM ----------------
  typedef enum logic [1:0] {StIdle, StWait, StAck, StRel} in_state_e;
  in_state_e   r_in_state, w_in_next;
  logic [31:0] r_in_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_state <= StIdle;
      r_in_data  <= '0;
    end else begin
      r_in_state <= w_in_next;
      if (r_in_state == StWait && r_press) begin
        r_in_data <= {{(32 - SW_WIDTH){1'b0}}, io_bus.sw};
      end
    end
  end

  always_comb begin
    w_in_next = r_in_state;
    unique case (r_in_state)
      StIdle:  if (io_bus.in_req) w_in_next = StWait;
      StWait:  if (r_press) w_in_next = StAck;
      StAck:   w_in_next = StRel;
      StRel:   if (r_db) w_in_next = StIdle;
      default: w_in_next = StIdle;
    endcase
  end

  // ---------------- OUT conversion FSM ----------------
  typedef enum logic [1:0] {CvIdle, CvShift, CvFin, CvDisp} cv_state_e;
  cv_state_e   r_cv_state, w_cv_next;
  logic        r_neg, r_ovf, r_armed, r_minus;
  logic [23:0] r_bin;
  logic [27:0] r_bcd;
  logic [4:0]  r_shift_cnt;
  logic [6:0]  r_hex [7];
  logic        w_busy, w_start, w_stall, w_seen;
  logic [31:0] w_abs;
  logic [27:0] w_bcd_adj;
  logic [6:0]  w_hex_new [7];

  assign w_busy  = (r_cv_state == CvShift) || (r_cv_state == CvFin);
  assign w_start = io_bus.out_req && !w_busy && r_armed;
  assign w_stall = (io_bus.in_req && r_in_state != StAck) || (io_bus.out_req && w_busy);
  // -2^31 negates to itself and lands in the overflow range
  assign w_abs   = io_bus.out_data[31] ? (32'd0 - io_bus.out_data) : io_bus.out_data;

  always_comb begin
    w_cv_next = r_cv_state;
    unique case (r_cv_state)
      CvIdle:  if (w_start) w_cv_next = CvShift;
      CvShift: if (r_shift_cnt == 5'd23) w_cv_next = CvFin;
      CvFin:   w_cv_next = CvDisp;
      CvDisp:  w_cv_next = w_start ? CvShift : CvIdle;
      default: w_cv_next = CvIdle;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 7; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero blanking from the top digit down; hex0 always shown
  always_comb begin
    w_seen = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (r_bcd[4*i +: 4] != 4'd0 || i == 0) w_seen = 1'b1;
      w_hex_new[i] = w_seen ? seg7(r_bcd[4*i +: 4]) : 7'h7F;
    end
    if (r_ovf) begin
      for (int i = 1; i < 7; i++) w_hex_new[i] = 7'h7F;
      w_hex_new[0] = 7'h06;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cv_state  <= CvIdle;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_armed     <= 1'b1;
      r_minus     <= 1'b0;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_shift_cnt <= '0;
      for (int i = 0; i < 7; i++) r_hex[i] <= (i == 0) ? 7'h40 : 7'h7F;
    end else begin
      r_cv_state <= w_cv_next;
      // A stall-free cycle means the PC advanced, so the next out_req is a new instruction
      if (!io_bus.out_req || !w_stall) r_armed <= 1'b1;
      else if (w_start)                r_armed <= 1'b0;
      if (w_start) begin
        r_neg       <= io_bus.out_data[31];
        r_ovf       <= (w_abs > 32'd9_999_999);
        r_bin       <= w_abs[23:0];
        r_bcd       <= '0;
        r_shift_cnt <= '0;
      end else if (r_cv_state == CvShift) begin
        {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
        r_shift_cnt    <= r_shift_cnt + 5'd1;
      end
      if (r_cv_state == CvDisp) begin
        for (int i = 0; i < 7; i++) r_hex[i] <= w_hex_new[i];
        r_minus <= r_neg && !r_ovf;
      end
    end
  end

  assign io_bus.in_data = r_in_data;
  assign io_bus.stall   = w_stall;
  assign io_bus.hex0    = r_hex[0];
  assign io_bus.hex1    = r_hex[1];
  assign io_bus.hex2    = r_hex[2];
  assign io_bus.hex3    = r_hex[3];
  assign io_bus.hex4    = r_hex[4];
  assign io_bus.hex5    = r_hex[5];
  assign io_bus.hex6    = r_hex[6];
  assign io_bus.hex7    = io_bus.halt ? 7'h09 : (r_minus ? 7'h3F : 7'h7F);
endmodule
